// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Package     : alu_pkg
// Description : Shared encodings for the bit-serial arithmetic sequencer:
//               slice operation selects and sequencer FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

   // Slice operand-B selection: A+B, A+~B, A+0, A+all-ones (each plus cin)
   localparam logic [1:0] SEL_ADD = 2'b00;
   localparam logic [1:0] SEL_SUB = 2'b01;
   localparam logic [1:0] SEL_INC = 2'b10;
   localparam logic [1:0] SEL_DEC = 2'b11;

   // Sequencer FSM states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } seq_state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/serial_arith_slice.sv
`default_nettype none
// ============================================================================
// Module      : serial_arith_slice
// Description : Combinational 1-bit arithmetic slice. Operand B is replaced
//               by B, ~B, 0 or 1 according to sel, then fed with A and the
//               incoming carry into a full adder.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_arith_slice
   import alu_pkg::*;
(
   input  logic       a,
   input  logic       b,
   input  logic [1:0] sel,
   input  logic       cin,
   output logic       sum,
   output logic       cout
);

   logic w_b_eff;

   // Operand-B mux: pass, invert, force 0 or force 1
   always_comb begin
      w_b_eff = b;
      case (sel)
         SEL_ADD: w_b_eff = b;
         SEL_SUB: w_b_eff = ~b;
         SEL_INC: w_b_eff = 1'b0;
         SEL_DEC: w_b_eff = 1'b1;
         default: w_b_eff = b;
      endcase
   end

   // Full adder
   assign sum  = a ^ w_b_eff ^ cin;
   assign cout = (a & w_b_eff) | (a & cin) | (w_b_eff & cin);

endmodule : serial_arith_slice
`default_nettype wire

// File: rtl/serial_arith_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : serial_arith_sequencer
// Description : Bit-serial driver for the 1-bit arithmetic slice. Accepts one
//               WIDTH-bit operation, processes it LSB first one bit per clock
//               through a carry flop, and presents the result with carry,
//               signed-overflow and zero flags on a valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_arith_sequencer
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             op_valid_i,
   output logic             op_ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [1:0]       sel_i,
   input  logic             cin_i,
   output logic             res_valid_o,
   input  logic             res_ready_i,
   output logic [WIDTH-1:0] d_o,
   output logic             cout_o,
   output logic             ovf_o,
   output logic             zero_o
);

   localparam int              CNT_W  = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

   seq_state_t       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_d;
   logic [1:0]       r_sel;
   logic             r_carry;
   logic             r_msb_cin;

   logic             w_sum;
   logic             w_cout;
   logic [WIDTH-1:0] w_d_next;

   serial_arith_slice u_slice (
      .a    (r_a[0]),
      .b    (r_b[0]),
      .sel  (r_sel),
      .cin  (r_carry),
      .sum  (w_sum),
      .cout (w_cout)
   );

   // Result register after the current bit has been shifted in at the MSB
   assign w_d_next = {w_sum, r_d[WIDTH-1:1]};

   // Both operands of the XOR only update on the RUN->DONE edge, so the flag
   // is steady for the whole DONE period
   assign ovf_o = r_msb_cin ^ cout_o;
   assign d_o   = r_d;

   // Sequencer FSM with registered handshake and flag outputs
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state     <= IDLE;
         op_ready_o  <= 1'b1;
         res_valid_o <= 1'b0;
         r_cnt       <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_d         <= '0;
         r_sel       <= SEL_ADD;
         r_carry     <= 1'b0;
         r_msb_cin   <= 1'b0;
         cout_o      <= 1'b0;
         zero_o      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (op_valid_i && op_ready_o) begin
                  r_a        <= a_i;
                  r_b        <= b_i;
                  r_sel      <= sel_i;
                  r_carry    <= cin_i;
                  r_cnt      <= '0;
                  op_ready_o <= 1'b0;
                  r_state    <= RUN;
               end
            end
            RUN: begin
               r_a     <= r_a >> 1;
               r_b     <= r_b >> 1;
               r_d     <= w_d_next;
               r_carry <= w_cout;
               if (r_cnt == C_LAST) begin
                  // Carry into the MSB feeds the signed-overflow flag
                  r_msb_cin   <= r_carry;
                  cout_o      <= w_cout;
                  zero_o      <= ~|w_d_next;
                  res_valid_o <= 1'b1;
                  r_state     <= DONE;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            DONE: begin
               if (res_ready_i) begin
                  res_valid_o <= 1'b0;
                  op_ready_o  <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: begin
               res_valid_o <= 1'b0;
               op_ready_o  <= 1'b1;
               r_state     <= IDLE;
            end
         endcase
      end
   end

endmodule : serial_arith_sequencer
`default_nettype wire
